// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The controller attaches through the slave modport, the datapath through master.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        ID_UsesRt;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic        BranchTaken;
    logic        MulStart;
    logic        ExtStall;

    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXWrite;
    logic        IDEXFlush;
    logic        Busy;
    logic [31:0] StallCount;
    logic [31:0] FlushCount;

    modport master (
        output IFID_Rs, IFID_Rt, ID_UsesRt, IDEX_MemRead, IDEX_Rt,
               BranchTaken, MulStart, ExtStall,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
               Busy, StallCount, FlushCount
    );

    modport slave (
        input  IFID_Rs, IFID_Rt, ID_UsesRt, IDEX_MemRead, IDEX_Rt,
               BranchTaken, MulStart, ExtStall,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
               Busy, StallCount, FlushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, branch flushes,
// multi-cycle multiply hold and external freeze. Define HAZARD_STATS_EN for stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_e;

    // Cnt counts the wait cycles still owed after the issuing RUN cycle.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 2);

    state_e     r_state;
    logic [3:0] r_cnt;

    logic w_loadUse;
    logic w_pcWrite;
    logic w_ifidWrite;
    logic w_ifidFlush;
    logic w_idexWrite;
    logic w_idexFlush;
    logic w_busy;

    assign w_loadUse = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                       ((hz.IDEX_Rt == hz.IFID_Rs) ||
                        (hz.ID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else if (!hz.ExtStall) begin
            case (r_state)
                RUN: begin
                    if (!hz.BranchTaken && !w_loadUse && hz.MulStart) begin
                        r_state <= MUL_WAIT;
                        r_cnt   <= MUL_LOAD;
                    end
                end
                MUL_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RUN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_pcWrite   = 1'b1;
        w_ifidWrite = 1'b1;
        w_idexWrite = 1'b1;
        w_ifidFlush = 1'b0;
        w_idexFlush = 1'b0;
        w_busy      = 1'b0;
        if (Rst) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_idexWrite = 1'b0;
            w_ifidFlush = 1'b1;
            w_idexFlush = 1'b1;
        end else if (r_state == MUL_WAIT) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_idexWrite = 1'b0;
            w_busy      = 1'b1;
        end else if (hz.ExtStall) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_idexWrite = 1'b0;
        end else if (hz.BranchTaken) begin
            w_ifidFlush = 1'b1;
            w_idexFlush = 1'b1;
        end else if (w_loadUse) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_idexFlush = 1'b1;
        end
    end

    assign hz.PCWrite   = w_pcWrite;
    assign hz.IFIDWrite = w_ifidWrite;
    assign hz.IFIDFlush = w_ifidFlush;
    assign hz.IDEXWrite = w_idexWrite;
    assign hz.IDEXFlush = w_idexFlush;
    assign hz.Busy      = w_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCount;
    logic [31:0] r_flushCount;
    logic        w_countStall;
    logic        w_countFlush;

    // Freeze cycles are not hazards, so they never count as stalls.
    assign w_countStall = !hz.ExtStall && !w_pcWrite;
    assign w_countFlush = (r_state == RUN) && !hz.ExtStall && hz.BranchTaken;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stallCount <= 32'd0;
            r_flushCount <= 32'd0;
        end else begin
            if (w_countStall && (r_stallCount != 32'hFFFF_FFFF)) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
            if (w_countFlush && (r_flushCount != 32'hFFFF_FFFF)) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign hz.StallCount = r_stallCount;
    assign hz.FlushCount = r_flushCount;
`else
    assign hz.StallCount = 32'd0;
    assign hz.FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors with literal checks
// plus a per-cycle comparison against a cycle-count model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 4;
`ifdef HAZARD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    // Control vector order: PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, Busy
    localparam logic [5:0] V_DEFAULT = 6'b110100;
    localparam logic [5:0] V_RESET   = 6'b001010;
    localparam logic [5:0] V_LOADUSE = 6'b000110;
    localparam logic [5:0] V_BRANCH  = 6'b111110;
    localparam logic [5:0] V_FREEZE  = 6'b000000;
    localparam logic [5:0] V_MULWAIT = 6'b000001;

    logic Clk;
    logic Rst;
    int   assertCount;
    int   failCount;

    pipeline_hazard_ctrl_if hzIf ();

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .hz  (hzIf)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Model state: wait cycles still owed by an in-flight multiply, and hazard tallies.
    int          mulLeft;
    int unsigned expStall;
    int unsigned expFlush;
    bit          modelReady;

    function automatic bit loadUseHazard();
        return hzIf.IDEX_MemRead && (hzIf.IDEX_Rt != 5'd0) &&
               ((hzIf.IDEX_Rt == hzIf.IFID_Rs) ||
                (hzIf.ID_UsesRt && (hzIf.IDEX_Rt == hzIf.IFID_Rt)));
    endfunction

    function automatic logic [5:0] expectedCtrl();
        if (Rst)                  return V_RESET;
        else if (mulLeft > 0)     return V_MULWAIT;
        else if (hzIf.ExtStall)   return V_FREEZE;
        else if (hzIf.BranchTaken) return V_BRANCH;
        else if (loadUseHazard()) return V_LOADUSE;
        else                      return V_DEFAULT;
    endfunction

    function automatic logic [5:0] actualCtrl();
        return {hzIf.PCWrite, hzIf.IFIDWrite, hzIf.IFIDFlush,
                hzIf.IDEXWrite, hzIf.IDEXFlush, hzIf.Busy};
    endfunction

    initial begin
        mulLeft    = 0;
        expStall   = 0;
        expFlush   = 0;
        modelReady = 1'b0;
    end

    always @(posedge Clk) begin
        if (Rst) begin
            mulLeft  = 0;
            expStall = 0;
            expFlush = 0;
        end else if (!hzIf.ExtStall) begin
            if (mulLeft > 0) begin
                mulLeft  = mulLeft - 1;
                expStall = expStall + 1;
            end else if (hzIf.BranchTaken) begin
                expFlush = expFlush + 1;
            end else if (loadUseHazard()) begin
                expStall = expStall + 1;
            end else if (hzIf.MulStart) begin
                mulLeft = MUL_LAT - 1;
            end
        end
        modelReady = 1'b1;
    end

    always @(negedge Clk) begin
        if (modelReady) begin
            assertCount++;
            if (actualCtrl() !== expectedCtrl()) begin
                failCount++;
                $display("[TB] FAIL modelCtrl t=%0t got=%b expected=%b", $time, actualCtrl(), expectedCtrl());
            end
            assertCount++;
            if ((hzIf.StallCount !== (STATS_EN ? expStall : 32'd0)) ||
                (hzIf.FlushCount !== (STATS_EN ? expFlush : 32'd0))) begin
                failCount++;
                $display("[TB] FAIL modelCounts t=%0t got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         $time, hzIf.StallCount, hzIf.FlushCount,
                         STATS_EN ? expStall : 0, STATS_EN ? expFlush : 0);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRt, input logic memRead, input logic [4:0] idexRt,
                                 input logic br, input logic mul, input logic ext);
        @(posedge Clk);
        #1;
        Rst               = rst;
        hzIf.IFID_Rs      = rs;
        hzIf.IFID_Rt      = rt;
        hzIf.ID_UsesRt    = usesRt;
        hzIf.IDEX_MemRead = memRead;
        hzIf.IDEX_Rt      = idexRt;
        hzIf.BranchTaken  = br;
        hzIf.MulStart     = mul;
        hzIf.ExtStall     = ext;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expCtrl);
        @(negedge Clk);
        assertCount++;
        if (actualCtrl() !== expCtrl) begin
            failCount++;
            $display("[TB] FAIL %s got=%b expected=%b", name, actualCtrl(), expCtrl);
        end
    endtask

    task automatic checkCounts(input string name, input logic [31:0] stall, input logic [31:0] flush);
        assertCount++;
        if ((hzIf.StallCount !== stall) || (hzIf.FlushCount !== flush)) begin
            failCount++;
            $display("[TB] FAIL %s got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, hzIf.StallCount, hzIf.FlushCount, stall, flush);
        end
    endtask

    initial begin
        assertCount       = 0;
        failCount         = 0;
        Rst               = 1'b1;
        hzIf.IFID_Rs      = 5'd0;
        hzIf.IFID_Rt      = 5'd0;
        hzIf.ID_UsesRt    = 1'b0;
        hzIf.IDEX_MemRead = 1'b0;
        hzIf.IDEX_Rt      = 5'd0;
        hzIf.BranchTaken  = 1'b0;
        hzIf.MulStart     = 1'b0;
        hzIf.ExtStall     = 1'b0;

        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("resetOutputs", V_RESET);
        applyIdle();
        checkOutput("afterReset", V_DEFAULT);
        checkCounts("resetCounts", 32'd0, 32'd0);

        // lw $5 followed by a use of $5 as rs
        applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("loadUseRs", V_LOADUSE);
        applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("loadUseRelease", V_DEFAULT);

        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("loadToR0", V_DEFAULT);
        applyStimulus(1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("loadUseRt", V_LOADUSE);
        applyStimulus(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("rtNotRead", V_DEFAULT);

        applyStimulus(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("branchOverLoadUse", V_BRANCH);
        applyStimulus(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
        checkOutput("freezeOverAll", V_FREEZE);

        // Plain multiply: one issue cycle, MUL_LAT-1 wait cycles
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("mulIssue", V_DEFAULT);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            applyStimulus(1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
            checkOutput("mulWait", V_MULWAIT);
        end
        applyIdle();
        checkOutput("mulDone", V_DEFAULT);

        // Multiply with a two-cycle freeze in the middle of the wait
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("mulIssue2", V_DEFAULT);
        applyIdle();
        checkOutput("mulWait2a", V_MULWAIT);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            checkOutput("mulWaitFrozen", V_MULWAIT);
        end
        applyIdle();
        checkOutput("mulWait2b", V_MULWAIT);
        applyIdle();
        checkOutput("mulWait2c", V_MULWAIT);
        applyIdle();
        checkOutput("mulDone2", V_DEFAULT);

        // Reset on the second wait cycle abandons the multiply
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("mulIssue3", V_DEFAULT);
        applyIdle();
        checkOutput("mulWait3a", V_MULWAIT);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("resetInMulWait", V_RESET);
        applyIdle();
        checkOutput("runAfterReset", V_DEFAULT);
        checkCounts("countsAfterReset", 32'd0, 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
            checkOutput("repeatLoadUse", V_LOADUSE);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("branchOnly", V_BRANCH);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("frozenBranch", V_FREEZE);
        applyIdle();
        checkOutput("finalIdle", V_DEFAULT);
        checkCounts("tallyCounts", STATS_EN ? 32'd3 : 32'd0, STATS_EN ? 32'd1 : 32'd0);

        @(posedge Clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
